i2s_receiver: RTL and testbench
===============================

I2S_RECEIVER -- requirements
Module: i2s_receiver

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning the PCM word width delivered per channel.
REQ-002 SHALL have parameter SLOT_W, default 32, meaning the maximum legal bits per channel slot.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic SHALL be in this domain.
REQ-004 SHALL have port rst, input, 1: one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port enable, input, 1, receive enable.
REQ-006 SHALL have port i2s_bclk, input, 1, external bit clock, asynchronous to clk.
REQ-007 SHALL have port i2s_lrclk, input, 1, word select; low = left, high = right.
REQ-008 SHALL have port i2s_sd, input, 1, serial data, MSB first.
REQ-009 SHALL have port pcm_valid, output, 1, one-clk pulse when a new stereo pair is presented.
REQ-010 SHALL have ports pcm_l and pcm_r, output, DATA_W each, the last completed left and right words.
REQ-011 SHALL have port frame_err, output, 1, one-clk pulse on slot overrun.

Function
REQ-012 SHALL pass i2s_bclk, i2s_lrclk and i2s_sd each through a 2-flop synchronizer before use.
REQ-013 SHALL act only on a "bit edge": the clk cycle in which synchronized bclk is 1 and was 0 the previous cycle; legal bclk frequency is at most clk/4.
REQ-014 SHALL, at each bit edge, sample synchronized sd and lrclk together.
REQ-015 SHALL treat a bit edge whose sampled lrclk differs from the previous bit edge's lrclk as a boundary edge; the sd bit at a boundary edge is the last bit of the ending slot (standard I2S one-bit delay).
REQ-016 SHALL keep a per-slot bit counter cnt, starting at 0 after each boundary edge, saturating at SLOT_W.
REQ-017 SHALL store the bit at index cnt into word position DATA_W-1-cnt when cnt < DATA_W, and discard it otherwise; unfilled LSBs SHALL be zero.
REQ-018 SHALL implement the states SYNC, LEFT and RIGHT.
REQ-019 SYNC SHALL move to LEFT on the first boundary edge with lrclk 1->0 and discard all data before it.
REQ-020 LEFT SHALL move to RIGHT on a 0->1 boundary edge and latch the left word internally.
REQ-021 RIGHT SHALL move to LEFT on a 1->0 boundary edge, update pcm_l and pcm_r together, and pulse pcm_valid exactly 1 clk after that boundary edge cycle.
REQ-022 SHALL pulse frame_err 1 clk after any bit edge at which cnt would exceed SLOT_W; the word is still delivered.
REQ-023 Simultaneous events: a boundary edge that also overruns SHALL produce both pcm_valid (when in RIGHT) and frame_err in the same cycle.
REQ-024 enable low SHALL force SYNC and clear cnt and the word shift register; pcm_l and pcm_r SHALL hold, and pcm_valid SHALL stay 0.

Reset
REQ-025 rst high SHALL immediately force SYNC, cnt=0, synchronizer flops=0, pcm_valid=0, frame_err=0, pcm_l=0, pcm_r=0.
REQ-026 Reset asserted mid-frame SHALL discard the partial pair; the first pcm_valid after release SHALL need a full LEFT+RIGHT frame after a 1->0 boundary.

Configuration
REQ-027 Macro I2S_RX_ERR_EN defined: the overrun detection of REQ-022 SHALL be compiled in.
REQ-028 Macro I2S_RX_ERR_EN undefined: frame_err SHALL be tied 0, and cnt SHALL only be wide enough to reach DATA_W.

Structure
REQ-029 Package kosei_audio_pkg SHALL hold PCM_W=24, I2S_SLOT_W=32 and the rx_state_t enum (SYNC, LEFT, RIGHT).
REQ-030 SHALL instantiate sub-module sync_2ff three times, once per async input; all other logic SHALL be flat.

Verification (clk 100 MHz, bclk = clk/8, 32-bit slots)
REQ-031 After reset, send L=0x123456, R=0xABCDEF -> one pcm_valid pulse; pcm_l=0x123456, pcm_r=0xABCDEF; frame_err=0.
REQ-032 Send 16-bit slots with L=0xA5A5, R=0x5A5A -> pcm_l=0xA5A500, pcm_r=0x5A5A00.
REQ-033 Start the stream mid-right-slot -> no pcm_valid until the first complete L/R pair, which SHALL match the sent data.
REQ-034 Send a 40-bit left slot with the macro defined -> frame_err pulses once, pcm_l holds the first 24 bits; with the macro undefined, frame_err stays 0.
REQ-035 Assert rst during the right slot, release, then send two frames -> no stale output, and exactly two pcm_valid pulses with the correct data.
REQ-036 Drop enable for one frame, then restore it -> no pcm_valid during the dropped frame, outputs hold, and output resumes on the next full frame.

Source files
------------

// File: rtl/kosei_audio_pkg.sv
// kosei_audio_pkg
// Shared audio constants and the I2S receiver state encoding.
//   PCM_W       : PCM word width delivered per channel
//   I2S_SLOT_W  : maximum legal bits per I2S channel slot
//   rx_state_t  : receiver framing state (SYNC, LEFT, RIGHT)
package kosei_audio_pkg;

    localparam int PCM_W      = 24;
    localparam int I2S_SLOT_W = 32;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for one asynchronous single-bit input.
// Ports:
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset, clears both flops
//   d_i   : asynchronous input
//   q_o   : synchronized output (two clk_i cycles of latency)
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/i2s_receiver.sv
// i2s_receiver
// Oversampling I2S receiver. The bit clock, word select and serial data are
// synchronized into clk and sampled on detected rising edges of the bit clock.
// Words are MSB first with the standard one-bit delay after a word-select
// change. A stereo pair is presented on pcm_l/pcm_r with a one-clk pcm_valid
// pulse when the right slot ends.
//
// Compile-time option:
//   I2S_RX_ERR_EN : when defined, slot overrun detection drives frame_err;
//                   otherwise frame_err is tied low and the bit counter only
//                   counts up to DATA_W.
//
// Ports:
//   clk        : system clock, all logic in this domain
//   rst        : asynchronous active-high reset
//   enable     : receive enable; low forces resynchronization
//   i2s_bclk   : external bit clock (async, at most clk/4)
//   i2s_lrclk  : word select, low = left, high = right
//   i2s_sd     : serial data, MSB first
//   pcm_valid  : one-clk pulse when a new stereo pair is presented
//   pcm_l      : last completed left word
//   pcm_r      : last completed right word
//   frame_err  : one-clk pulse on slot overrun
module i2s_receiver
    import kosei_audio_pkg::*;
#(
    parameter int DATA_W = PCM_W,
    parameter int SLOT_W = I2S_SLOT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              i2s_bclk,
    input  logic              i2s_lrclk,
    input  logic              i2s_sd,
    output logic              pcm_valid,
    output logic [DATA_W-1:0] pcm_l,
    output logic [DATA_W-1:0] pcm_r,
    output logic              frame_err
);

`ifdef I2S_RX_ERR_EN
    localparam int CNT_MAX = SLOT_W;
`else
    localparam int CNT_MAX = DATA_W;
`endif
    localparam int              CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);

    // ------------------------------------------------------------------
    // Input synchronization
    // ------------------------------------------------------------------
    logic bclk_s;
    logic lr_s;
    logic sd_s;

    sync_2ff u_sync_bclk (.clk_i(clk), .rst_i(rst), .d_i(i2s_bclk),  .q_o(bclk_s));
    sync_2ff u_sync_lr   (.clk_i(clk), .rst_i(rst), .d_i(i2s_lrclk), .q_o(lr_s));
    sync_2ff u_sync_sd   (.clk_i(clk), .rst_i(rst), .d_i(i2s_sd),    .q_o(sd_s));

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    rx_state_t         state_q;
    logic              bclk_prev_q;
    logic              lr_prev_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] left_q;
    logic [DATA_W-1:0] pcm_l_q;
    logic [DATA_W-1:0] pcm_r_q;
    logic              valid_q;

    logic              bit_edge;
    logic              boundary;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] word_d;

    assign bit_edge = bclk_s & ~bclk_prev_q;
    // lr_prev_q tracks word select at every bit edge, even while disabled,
    // so the first boundary after re-enable is classified correctly.
    assign boundary = lr_s ^ lr_prev_q;
    assign cnt_d    = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;

    // Current word with this edge's bit merged in; bits past DATA_W match no
    // position and are dropped.
    always_comb begin
        word_d = word_q;
        for (int i = 0; i < DATA_W; i++) begin
            if (int'(cnt_q) == DATA_W - 1 - i) begin
                word_d[i] = sd_s;
            end
        end
    end

`ifdef I2S_RX_ERR_EN
    logic err_q;
    logic ovf_q;    // overrun already reported for the current slot
    logic overrun;

    assign overrun = bit_edge && (state_q != SYNC) && (cnt_q == CNT_SAT) && !ovf_q;
`endif

    // ------------------------------------------------------------------
    // Framing FSM and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SYNC;
            bclk_prev_q <= 1'b0;
            lr_prev_q   <= 1'b0;
            cnt_q       <= '0;
            word_q      <= '0;
            left_q      <= '0;
            pcm_l_q     <= '0;
            pcm_r_q     <= '0;
            valid_q     <= 1'b0;
`ifdef I2S_RX_ERR_EN
            err_q       <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            bclk_prev_q <= bclk_s;
            valid_q     <= 1'b0;
`ifdef I2S_RX_ERR_EN
            err_q       <= 1'b0;
`endif
            if (bit_edge) begin
                lr_prev_q <= lr_s;
            end

            if (!enable) begin
                state_q <= SYNC;
                cnt_q   <= '0;
                word_q  <= '0;
`ifdef I2S_RX_ERR_EN
                ovf_q   <= 1'b0;
`endif
            end else if (bit_edge) begin
                case (state_q)
                    SYNC: begin
                        cnt_q  <= '0;
                        word_q <= '0;
                        if (boundary && !lr_s) begin
                            state_q <= LEFT;
                        end
                    end
                    LEFT, RIGHT: begin
`ifdef I2S_RX_ERR_EN
                        err_q <= overrun;
`endif
                        if (boundary) begin
                            // Boundary bit closes the ending slot.
                            cnt_q  <= '0;
                            word_q <= '0;
`ifdef I2S_RX_ERR_EN
                            ovf_q  <= 1'b0;
`endif
                            if (state_q == LEFT) begin
                                left_q  <= word_d;
                                state_q <= RIGHT;
                            end else begin
                                pcm_l_q <= left_q;
                                pcm_r_q <= word_d;
                                valid_q <= 1'b1;
                                state_q <= LEFT;
                            end
                        end else begin
                            cnt_q  <= cnt_d;
                            word_q <= word_d;
`ifdef I2S_RX_ERR_EN
                            ovf_q  <= ovf_q | overrun;
`endif
                        end
                    end
                    default: state_q <= SYNC;
                endcase
            end
        end
    end

    assign pcm_valid = valid_q;
    assign pcm_l     = pcm_l_q;
    assign pcm_r     = pcm_r_q;
`ifdef I2S_RX_ERR_EN
    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// tb_i2s_receiver
// Directed bench for i2s_receiver: clk 100 MHz, bclk = clk/8.
module tb_i2s_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        i2s_bclk;
    logic        i2s_lrclk;
    logic        i2s_sd;
    logic        pcm_valid;
    logic [23:0] pcm_l;
    logic [23:0] pcm_r;
    logic        frame_err;

    int total = 0;
    int bad   = 0;

    logic [23:0] hist_l[$];
    logic [23:0] hist_r[$];
    int          err_total  = 0;
    int          both_total = 0;
    logic        pending;

    i2s_receiver #(.DATA_W(24), .SLOT_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_sd    (i2s_sd),
        .pcm_valid (pcm_valid),
        .pcm_l     (pcm_l),
        .pcm_r     (pcm_r),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Pulse monitor: every pcm_valid cycle logs the presented pair.
    always @(negedge clk) begin
        if (pcm_valid === 1'b1) begin
            hist_l.push_back(pcm_l);
            hist_r.push_back(pcm_r);
        end
        if (frame_err === 1'b1) err_total++;
        if (pcm_valid === 1'b1 && frame_err === 1'b1) both_total++;
    end

    // One bit: data/word select change while bclk low, then bclk high.
    task automatic send_bit(input logic lr, input logic b);
        @(negedge clk);
        i2s_bclk = 1'b0; i2s_lrclk = lr; i2s_sd = b;
        repeat (3) @(negedge clk);
        i2s_bclk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    // Slot bits 0..n-2; the last bit goes out on the next slot's first edge.
    task automatic send_body(input logic lr, input logic [63:0] s, input int n);
        for (int j = 0; j < n - 1; j++) send_bit(lr, s[63-j]);
        pending = s[64-n];
    endtask

    task automatic send_slot(input logic lr, input logic [63:0] s, input int n);
        send_bit(lr, pending);
        send_body(lr, s, n);
    endtask

    task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input int n);
        send_slot(1'b0, {l, 40'h0}, n);
        send_slot(1'b1, {r, 40'h0}, n);
    endtask

    // Closing 1->0 edge that completes the last right slot.
    task automatic flush();
        send_bit(1'b0, pending);
        repeat (6) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b1;
        i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_sd = 1'b0; pending = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1;
        i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_sd = 1'b0; pending = 1'b0;
        repeat (2) @(negedge clk);
        i2s_bclk = 1'b1; i2s_lrclk = 1'b1; i2s_sd = 1'b1;
        repeat (4) @(negedge clk);
        total++; if (pcm_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", pcm_valid); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", frame_err); end
        total++; if (pcm_l !== 24'h0) begin bad++; $display("FAIL reset_l got=%h exp=000000", pcm_l); end
        total++; if (pcm_r !== 24'h0) begin bad++; $display("FAIL reset_r got=%h exp=000000", pcm_r); end
        i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_sd = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        int v0, e0;
        do_reset();
        v0 = hist_l.size(); e0 = err_total;
        send_slot(1'b1, 64'h0, 32);
        send_frame(24'h123456, 24'hABCDEF, 32);
        flush();
        total++; if (hist_l.size() - v0 != 1) begin bad++; $display("FAIL basic_count got=%0d exp=1", hist_l.size() - v0); end
        total++; if (pcm_l !== 24'h123456) begin bad++; $display("FAIL basic_l got=%h exp=123456", pcm_l); end
        total++; if (pcm_r !== 24'hABCDEF) begin bad++; $display("FAIL basic_r got=%h exp=abcdef", pcm_r); end
        total++; if (err_total != e0) begin bad++; $display("FAIL basic_err got=%0d exp=0", err_total - e0); end
    endtask

    task automatic test_slot16();
        int v0;
        do_reset();
        v0 = hist_l.size();
        send_slot(1'b1, 64'h0, 16);
        send_frame(24'hA5A500, 24'h5A5A00, 16);
        flush();
        total++; if (hist_l.size() - v0 != 1) begin bad++; $display("FAIL s16_count got=%0d exp=1", hist_l.size() - v0); end
        total++; if (pcm_l !== 24'hA5A500) begin bad++; $display("FAIL s16_l got=%h exp=a5a500", pcm_l); end
        total++; if (pcm_r !== 24'h5A5A00) begin bad++; $display("FAIL s16_r got=%h exp=5a5a00", pcm_r); end
    endtask

    task automatic test_midstream();
        int v0;
        do_reset();
        v0 = hist_l.size();
        // Join partway through a right slot with arbitrary data.
        for (int j = 0; j < 11; j++) send_bit(1'b1, j[0]);
        pending = 1'b1;
        send_slot(1'b0, {24'h0F1E2D, 40'h0}, 32);
        total++; if (hist_l.size() - v0 != 0) begin bad++; $display("FAIL mid_early got=%0d exp=0", hist_l.size() - v0); end
        send_slot(1'b1, {24'hC3B4A5, 40'h0}, 32);
        flush();
        total++; if (hist_l.size() - v0 != 1) begin bad++; $display("FAIL mid_count got=%0d exp=1", hist_l.size() - v0); end
        total++; if (pcm_l !== 24'h0F1E2D) begin bad++; $display("FAIL mid_l got=%h exp=0f1e2d", pcm_l); end
        total++; if (pcm_r !== 24'hC3B4A5) begin bad++; $display("FAIL mid_r got=%h exp=c3b4a5", pcm_r); end
    endtask

    task automatic test_overrun();
        int v0, e0, b0, exp_err, exp_both;
`ifdef I2S_RX_ERR_EN
        exp_err = 1; exp_both = 1;
`else
        exp_err = 0; exp_both = 0;
`endif
        // 40-bit left slot: one overrun, word is the first 24 bits.
        do_reset();
        v0 = hist_l.size(); e0 = err_total;
        send_slot(1'b1, 64'h0, 32);
        send_slot(1'b0, {24'h89ABCD, 40'h0}, 40);
        send_slot(1'b1, {24'h13579B, 40'h0}, 32);
        flush();
        total++; if (err_total - e0 != exp_err) begin bad++; $display("FAIL ovr_err got=%0d exp=%0d", err_total - e0, exp_err); end
        total++; if (hist_l.size() - v0 != 1) begin bad++; $display("FAIL ovr_count got=%0d exp=1", hist_l.size() - v0); end
        total++; if (pcm_l !== 24'h89ABCD) begin bad++; $display("FAIL ovr_l got=%h exp=89abcd", pcm_l); end
        total++; if (pcm_r !== 24'h13579B) begin bad++; $display("FAIL ovr_r got=%h exp=13579b", pcm_r); end
        // 33-bit right slot: the closing boundary edge itself overruns.
        do_reset();
        e0 = err_total; b0 = both_total;
        send_slot(1'b1, 64'h0, 32);
        send_slot(1'b0, {24'h2468AC, 40'h0}, 32);
        send_slot(1'b1, {24'hFEDCBA, 40'h0}, 33);
        flush();
        total++; if (both_total - b0 != exp_both) begin bad++; $display("FAIL ovr_both got=%0d exp=%0d", both_total - b0, exp_both); end
        total++; if (err_total - e0 != exp_err) begin bad++; $display("FAIL ovr_err33 got=%0d exp=%0d", err_total - e0, exp_err); end
        total++; if (pcm_r !== 24'hFEDCBA) begin bad++; $display("FAIL ovr_r33 got=%h exp=fedcba", pcm_r); end
    endtask

    task automatic test_rst_mid();
        int v0, e0;
        do_reset();
        send_slot(1'b1, 64'h0, 32);
        send_frame(24'h111111, 24'h222222, 32);
        send_slot(1'b0, {24'h333333, 40'h0}, 32);
        for (int j = 0; j < 10; j++) send_bit(1'b1, 1'b1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (pcm_l !== 24'h0) begin bad++; $display("FAIL rstmid_l got=%h exp=000000", pcm_l); end
        total++; if (pcm_r !== 24'h0) begin bad++; $display("FAIL rstmid_r got=%h exp=000000", pcm_r); end
        rst = 1'b0;
        v0 = hist_l.size(); e0 = err_total;
        for (int j = 0; j < 22; j++) send_bit(1'b1, 1'b1);
        send_frame(24'h4C4C4C, 24'h5D5D5D, 32);
        send_frame(24'h6E6E6E, 24'h7F7F7F, 32);
        flush();
        total++; if (hist_l.size() - v0 != 2) begin bad++; $display("FAIL rstmid_count got=%0d exp=2", hist_l.size() - v0); end
        if (hist_l.size() - v0 >= 1) begin
            total++; if (hist_l[v0] !== 24'h4C4C4C) begin bad++; $display("FAIL rstmid_l1 got=%h exp=4c4c4c", hist_l[v0]); end
            total++; if (hist_r[v0] !== 24'h5D5D5D) begin bad++; $display("FAIL rstmid_r1 got=%h exp=5d5d5d", hist_r[v0]); end
        end
        total++; if (pcm_l !== 24'h6E6E6E) begin bad++; $display("FAIL rstmid_l2 got=%h exp=6e6e6e", pcm_l); end
        total++; if (pcm_r !== 24'h7F7F7F) begin bad++; $display("FAIL rstmid_r2 got=%h exp=7f7f7f", pcm_r); end
        total++; if (err_total != e0) begin bad++; $display("FAIL rstmid_err got=%0d exp=0", err_total - e0); end
    endtask

    task automatic test_enable();
        int v0;
        do_reset();
        v0 = hist_l.size();
        send_slot(1'b1, 64'h0, 32);
        send_frame(24'h00FF00, 24'hFF00FF, 32);
        send_bit(1'b0, pending);          // delivers the first pair
        repeat (6) @(negedge clk);
        total++; if (hist_l.size() - v0 != 1) begin bad++; $display("FAIL en_first got=%0d exp=1", hist_l.size() - v0); end
        enable = 1'b0;
        v0 = hist_l.size();
        send_body(1'b0, {24'hAAAAAA, 40'h0}, 32);
        send_slot(1'b1, {24'h555555, 40'h0}, 32);
        total++; if (hist_l.size() - v0 != 0) begin bad++; $display("FAIL en_drop got=%0d exp=0", hist_l.size() - v0); end
        total++; if (pcm_l !== 24'h00FF00) begin bad++; $display("FAIL en_hold_l got=%h exp=00ff00", pcm_l); end
        total++; if (pcm_r !== 24'hFF00FF) begin bad++; $display("FAIL en_hold_r got=%h exp=ff00ff", pcm_r); end
        enable = 1'b1;
        send_frame(24'h765432, 24'h13ACE0, 32);
        flush();
        total++; if (hist_l.size() - v0 != 1) begin bad++; $display("FAIL en_resume got=%0d exp=1", hist_l.size() - v0); end
        total++; if (pcm_l !== 24'h765432) begin bad++; $display("FAIL en_l got=%h exp=765432", pcm_l); end
        total++; if (pcm_r !== 24'h13ACE0) begin bad++; $display("FAIL en_r got=%h exp=13ace0", pcm_r); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slot16();
        test_midstream();
        test_overrun();
        test_rst_mid();
        test_enable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
